// File: rtl/trap_pkg.sv
// trap_pkg: shared state encoding, cause width and cause codes for the trap entry sequencer.
package trap_pkg;

    localparam int TRAP_REASON_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SAVE   = 2'd2,
        ST_VECTOR = 2'd3
    } trap_state_t;

    localparam logic [TRAP_REASON_W-1:0] RSN_MISALIGN  = 4'h0;
    localparam logic [TRAP_REASON_W-1:0] RSN_FETCH_ERR = 4'h1;
    localparam logic [TRAP_REASON_W-1:0] RSN_ILLEGAL   = 4'h2;
    localparam logic [TRAP_REASON_W-1:0] RSN_BREAK     = 4'h3;
    localparam logic [TRAP_REASON_W-1:0] RSN_LOAD_ERR  = 4'h4;
    localparam logic [TRAP_REASON_W-1:0] RSN_STORE_ERR = 4'h5;
    localparam logic [TRAP_REASON_W-1:0] RSN_ECALL     = 4'h8;
    localparam logic [TRAP_REASON_W-1:0] RSN_TIMER_IRQ = 4'hB;
    localparam logic [TRAP_REASON_W-1:0] RSN_EXT_IRQ   = 4'hF;

    // Each vector slot is 16 bytes; the sum wraps modulo 2^32.
    function automatic logic [31:0] vec_target(input logic [31:0] base,
                                               input logic [TRAP_REASON_W-1:0] cause);
        return base + {24'd0, cause, 4'b0000};
    endfunction

endpackage

// File: rtl/trap_drain_cnt.sv
// trap_drain_cnt: counts DRAIN cycles from 0 after start and flags the final allowed cycle.
module trap_drain_cnt #(
    parameter int DRAIN_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       expired,
    output logic [7:0] count
);

    logic active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            count  <= 8'd0;
        end else if (start) begin
            active <= 1'b1;
            count  <= 8'd0;
        end else if (stop) begin
            active <= 1'b0;
            count  <= 8'd0;
        end else if (active) begin
            count  <= count + 8'd1;
        end
    end

    assign expired = active && (count == 8'(DRAIN_MAX - 1));

endmodule

// File: rtl/trap_entry_seq.sv
// trap_entry_seq: trap entry sequencer (flush, drain, save EPC/cause, vector fetch).
// Define TRAP_NEST_EN to hold one trap arriving while busy and launch it straight after VECTOR.
module trap_entry_seq
    import trap_pkg::*;
#(
    parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
    parameter int          DRAIN_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trap_req,
    input  logic [TRAP_REASON_W-1:0] trap_reason,
    input  logic [31:0]              pc_in,
    input  logic                     pipe_empty,
    input  logic                     fetch_ack,
    output logic                     pipe_flush,
    output logic                     save_we,
    output logic [31:0]              save_epc,
    output logic [TRAP_REASON_W-1:0] save_cause,
    output logic                     vec_valid,
    output logic [31:0]              vec_addr,
    output logic                     trap_busy,
    output logic                     drain_timeout,
    output logic                     trap_lost
);

    trap_state_t              state, state_d;
    logic [TRAP_REASON_W-1:0] cause_q;
    logic [31:0]              epc_q;
    logic [7:0]               drain_count;
    logic                     drain_exp;
    logic                     take_new;
    logic                     relaunch;
    logic                     drain_done;
    logic                     lost_ev;

    assign take_new   = (state == ST_IDLE) && trap_req;
    assign drain_done = (state == ST_DRAIN) && (pipe_empty || drain_exp);

`ifdef TRAP_NEST_EN
    logic                     pend_v;
    logic [TRAP_REASON_W-1:0] pend_cause;
    logic [31:0]              pend_pc;
    logic                     leave_vec;

    // A request arriving on the very edge that leaves VECTOR launches directly.
    assign leave_vec = (state == ST_VECTOR) && fetch_ack;
    assign relaunch  = leave_vec && (pend_v || trap_req);
    assign lost_ev   = trap_busy && trap_req && pend_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v     <= 1'b0;
            pend_cause <= '0;
            pend_pc    <= 32'd0;
        end else if (relaunch) begin
            pend_v     <= 1'b0;
        end else if (trap_busy && trap_req && !pend_v) begin
            pend_v     <= 1'b1;
            pend_cause <= trap_reason;
            pend_pc    <= pc_in;
        end
    end
`else
    assign relaunch = 1'b0;
    assign lost_ev  = trap_busy && trap_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (trap_req)   state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = ST_SAVE;
            ST_SAVE:                   state_d = ST_VECTOR;
            ST_VECTOR: if (fetch_ack)  state_d = relaunch ? ST_DRAIN : ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= '0;
            epc_q   <= 32'd0;
        end else if (take_new) begin
            cause_q <= trap_reason;
            epc_q   <= pc_in;
`ifdef TRAP_NEST_EN
        end else if (relaunch) begin
            cause_q <= pend_v ? pend_cause : trap_reason;
            epc_q   <= pend_v ? pend_pc : pc_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_timeout <= 1'b0;
            trap_lost     <= 1'b0;
        end else begin
            if ((state == ST_DRAIN) && drain_exp && !pipe_empty) drain_timeout <= 1'b1;
            if (lost_ev) trap_lost <= 1'b1;
        end
    end

    trap_drain_cnt #(
        .DRAIN_MAX(DRAIN_MAX)
    ) u_drain_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (take_new || relaunch),
        .stop   (drain_done),
        .expired(drain_exp),
        .count  (drain_count)
    );

    assign pipe_flush = (state == ST_DRAIN) && (drain_count == 8'd0);
    assign save_we    = (state == ST_SAVE);
    assign vec_valid  = (state == ST_VECTOR);
    assign trap_busy  = (state != ST_IDLE);
    assign save_epc   = epc_q;
    assign save_cause = cause_q;
    assign vec_addr   = vec_target(VEC_BASE, cause_q);

endmodule

// File: tb/tb_trap_entry_seq.sv
// tb_trap_entry_seq: randomized self-checking bench for trap_entry_seq against a per-trap outcome model.
module tb_trap_entry_seq;

    localparam int          DMAX  = 16;
    localparam logic [31:0] VBASE = 32'h0000_0080;

    logic        clk = 1'b0, rst_n = 1'b0, trap_req = 1'b0, pipe_empty = 1'b0, fetch_ack = 1'b0;
    logic [3:0]  trap_reason = 4'h0;
    logic [31:0] pc_in = 32'd0;
    logic        pipe_flush, save_we, vec_valid, trap_busy, drain_timeout, trap_lost;
    logic [31:0] save_epc, vec_addr;
    logic [3:0]  save_cause;
    logic [1:0]  x_flush, x_we, x_vv, x_busy, x_to, x_lost;
    logic [31:0] x_epc [2];
    logic [31:0] x_addr [2];
    logic [3:0]  x_cause [2];

    int total = 0, bad = 0;
    bit exp_to, exp_lost;

    always #5 clk = ~clk;

    trap_entry_seq #(.VEC_BASE(VBASE), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_reason(trap_reason), .pc_in(pc_in),
        .pipe_empty(pipe_empty), .fetch_ack(fetch_ack), .pipe_flush(pipe_flush), .save_we(save_we),
        .save_epc(save_epc), .save_cause(save_cause), .vec_valid(vec_valid), .vec_addr(vec_addr),
        .trap_busy(trap_busy), .drain_timeout(drain_timeout), .trap_lost(trap_lost));

    trap_entry_seq #(.VEC_BASE(32'hFFFF_FF00), .DRAIN_MAX(DMAX)) dut_b (
        .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_reason(trap_reason), .pc_in(pc_in),
        .pipe_empty(pipe_empty), .fetch_ack(fetch_ack), .pipe_flush(x_flush[0]), .save_we(x_we[0]),
        .save_epc(x_epc[0]), .save_cause(x_cause[0]), .vec_valid(x_vv[0]), .vec_addr(x_addr[0]),
        .trap_busy(x_busy[0]), .drain_timeout(x_to[0]), .trap_lost(x_lost[0]));

    trap_entry_seq #(.VEC_BASE(32'hFFFF_FFF8), .DRAIN_MAX(DMAX)) dut_c (
        .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_reason(trap_reason), .pc_in(pc_in),
        .pipe_empty(pipe_empty), .fetch_ack(fetch_ack), .pipe_flush(x_flush[1]), .save_we(x_we[1]),
        .save_epc(x_epc[1]), .save_cause(x_cause[1]), .vec_valid(x_vv[1]), .vec_addr(x_addr[1]),
        .trap_busy(x_busy[1]), .drain_timeout(x_to[1]), .trap_lost(x_lost[1]));

    task automatic do_reset();
        rst_n = 1'b0; trap_req = 1'b0; fetch_ack = 1'b0; pipe_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_to = 1'b0; exp_lost = 1'b0;
    endtask

    // One full trap; expectations come from the trap's parameters, not from cycle-level state.
    task automatic run_trap(input logic [3:0] rsn, input logic [31:0] pc, input int empty_at,
                            input int ack_dly, input bit req_vec, input string tag);
        int nd = 0, nf = 0, ns = 0, nv = 0, cyc, exp_nd;
        logic [31:0] ea;
        ea     = VBASE + (32'(rsn) << 4);
        exp_nd = (empty_at < DMAX) ? empty_at + 1 : DMAX;
        trap_req = 1'b1; trap_reason = rsn; pc_in = pc;
        pipe_empty = 1'($urandom); fetch_ack = 1'($urandom);
        @(posedge clk); #1;
        for (cyc = 0; cyc < 400 && trap_busy; cyc++) begin
            trap_req = 1'b0; trap_reason = 4'($urandom); pc_in = $urandom;
            fetch_ack = 1'($urandom); pipe_empty = 1'($urandom);
            if (pipe_flush) nf++;
            if (save_we) begin
                ns++;
                total++;
                if (save_epc !== pc || save_cause !== rsn) begin
                    bad++;
                    $display("FAIL %s save: epc=%h cause=%h want epc=%h cause=%h", tag, save_epc, save_cause, pc, rsn);
                end
            end else if (vec_valid) begin
                nv++;
                total++;
                if (vec_addr !== ea) begin
                    bad++;
                    $display("FAIL %s vec_addr: got %h want %h", tag, vec_addr, ea);
                end
                fetch_ack = (nv == ack_dly + 1);
                trap_req  = req_vec && (nv == 1);
            end else begin
                total++;
                if (pipe_flush !== (nd == 0)) begin
                    bad++;
                    $display("FAIL %s flush at drain %0d: got %b want %b", tag, nd, pipe_flush, nd == 0);
                end
                pipe_empty = (nd >= empty_at);
                nd++;
            end
            @(posedge clk); #1;
        end
        trap_req = 1'b0; fetch_ack = 1'b0;
        exp_to   = exp_to | (empty_at >= DMAX);
        exp_lost = exp_lost | req_vec;
        total++;
        if (trap_busy) begin bad++; $display("FAIL %s cycle budget: sequence never returned to idle", tag); end
        total++;
        if (nd != exp_nd) begin bad++; $display("FAIL %s drain cycles: got %0d want %0d", tag, nd, exp_nd); end
        total++;
        if (nf != 1) begin bad++; $display("FAIL %s flush pulses: got %0d want 1", tag, nf); end
        total++;
        if (ns != 1) begin bad++; $display("FAIL %s save_we cycles: got %0d want 1", tag, ns); end
        total++;
        if (nv != ack_dly + 1) begin bad++; $display("FAIL %s vec_valid cycles: got %0d want %0d", tag, nv, ack_dly + 1); end
        total++;
        if (vec_valid !== 1'b0) begin bad++; $display("FAIL %s vec_valid after ack: got %b want 0", tag, vec_valid); end
        total++;
        if (drain_timeout !== exp_to) begin bad++; $display("FAIL %s drain_timeout: got %b want %b", tag, drain_timeout, exp_to); end
        total++;
        if (trap_lost !== exp_lost) begin bad++; $display("FAIL %s trap_lost: got %b want %b", tag, trap_lost, exp_lost); end
        total++;
        if (save_epc !== pc || save_cause !== rsn) begin
            bad++;
            $display("FAIL %s save regs hold: epc=%h cause=%h want %h %h", tag, save_epc, save_cause, pc, rsn);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trap_req = 1'b1; trap_reason = 4'h7; pc_in = 32'h0000_1234;
        @(posedge clk); #1;
        total++;
        if ({pipe_flush, save_we, vec_valid, trap_busy, drain_timeout, trap_lost, save_epc, save_cause} !== 42'd0) begin
            bad++;
            $display("FAIL reset outputs: flush=%b we=%b vv=%b busy=%b to=%b lost=%b epc=%h cause=%h want all 0",
                     pipe_flush, save_we, vec_valid, trap_busy, drain_timeout, trap_lost, save_epc, save_cause);
        end
        @(posedge clk); #1;
        total++;
        if (trap_busy !== 1'b0) begin bad++; $display("FAIL reset hold busy: got %b want 0", trap_busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (trap_busy !== 1'b1 || pipe_flush !== 1'b1 || save_epc !== 32'h1234 || save_cause !== 4'h7) begin
            bad++;
            $display("FAIL first edge trap: busy=%b flush=%b epc=%h cause=%h want 1 1 00001234 7",
                     trap_busy, pipe_flush, save_epc, save_cause);
        end
        trap_req = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        run_trap(4'h5, 32'h0000_1000, 1, 2, 1'b0, "basic");
    endtask

    task automatic test_timeout();
        do_reset();
        run_trap(4'h2, 32'h0000_2000, DMAX - 1, 0, 1'b0, "last_cycle_empty");
        run_trap(4'h3, 32'h0000_3000, 1000, 1, 1'b0, "timeout");
    endtask

`ifdef TRAP_NEST_EN
    task automatic test_back_to_back();
        do_reset();
        trap_req = 1'b1; trap_reason = 4'h3; pc_in = 32'h0000_A000; pipe_empty = 1'b1; fetch_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1 trap_req = 1'b0; end
        trap_req = 1'b1; trap_reason = 4'h9; pc_in = 32'h0000_B000;
        @(posedge clk); #1;
        trap_req = 1'b0; fetch_ack = 1'b1;
        @(posedge clk); #1;
        fetch_ack = 1'b0;
        total++;
        if (trap_busy !== 1'b1 || pipe_flush !== 1'b1 || vec_valid !== 1'b0) begin
            bad++;
            $display("FAIL nest relaunch: busy=%b flush=%b vv=%b want 1 1 0", trap_busy, pipe_flush, vec_valid);
        end
        @(posedge clk); #1;
        total++;
        if (save_we !== 1'b1 || save_epc !== 32'h0000_B000 || save_cause !== 4'h9 || trap_lost !== 1'b0) begin
            bad++;
            $display("FAIL nest save: we=%b epc=%h cause=%h lost=%b want 1 0000b000 9 0",
                     save_we, save_epc, save_cause, trap_lost);
        end
        fetch_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 fetch_ack = 1'b0;
    endtask
`else
    task automatic test_back_to_back();
        do_reset();
        run_trap(4'h4, 32'h0000_4000, 0, 2, 1'b1, "lost");
    endtask
`endif

    task automatic test_reset_save();
        do_reset();
        trap_req = 1'b1; trap_reason = 4'h6; pc_in = 32'h0000_6000; pipe_empty = 1'b1;
        @(posedge clk); #1;
        trap_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (save_we !== 1'b1) begin bad++; $display("FAIL reach save: save_we=%b want 1", save_we); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({pipe_flush, save_we, vec_valid, trap_busy, drain_timeout, trap_lost, save_epc, save_cause} !== 42'd0) begin
            bad++;
            $display("FAIL async reset in save: we=%b vv=%b busy=%b epc=%h cause=%h want all 0",
                     save_we, vec_valid, trap_busy, save_epc, save_cause);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_ack = 1'($urandom);
            @(posedge clk); #1;
            total++;
            if (vec_valid !== 1'b0 || save_we !== 1'b0 || trap_busy !== 1'b0) begin
                bad++;
                $display("FAIL after reset %0d: vv=%b we=%b busy=%b want 0 0 0", i, vec_valid, save_we, trap_busy);
            end
        end
        fetch_ack = 1'b0;
    endtask

    task automatic test_vec_wrap();
        do_reset();
        run_trap(4'hF, 32'h0000_F000, 0, 0, 1'b0, "wrap_f");
        total++;
        if (x_addr[0] !== 32'hFFFF_FFF0) begin bad++; $display("FAIL wrap base ff00: got %h want fffffff0", x_addr[0]); end
        run_trap(4'h1, 32'h0000_0100, 2, 0, 1'b0, "wrap_1");
        total++;
        if (x_addr[1] !== 32'h0000_0008) begin bad++; $display("FAIL wrap base fff8: got %h want 00000008", x_addr[1]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 24; t++) begin
            int gap = $urandom_range(0, 3);
            repeat (gap) begin
                fetch_ack = 1'($urandom); pipe_empty = 1'($urandom);
                @(posedge clk); #1;
            end
            total++;
            if (trap_busy !== 1'b0) begin bad++; $display("FAIL random idle %0d: busy=%b want 0", t, trap_busy); end
            run_trap(4'($urandom), $urandom, $urandom_range(0, 20), $urandom_range(0, 3), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_back_to_back();
        test_reset_save();
        test_vec_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_entry_seq.md
TRAP_ENTRY_SEQ -- requirements
Module: trap_entry_seq

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0080: base address of the trap vector table.
REQ-002 SHALL have parameter DRAIN_MAX, default 16: maximum cycles spent waiting for pipeline drain, legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port trap_req, input, 1 bit: at least one trap source is active this cycle.
REQ-006 SHALL have port trap_reason, input, 4 bits: prioritised trap cause code from the trap priority encoder.
REQ-007 SHALL have port pc_in, input, 32 bits: PC of the faulting or interrupted instruction.
REQ-008 SHALL have port pipe_empty, input, 1 bit: the pipeline holds no in-flight instructions.
REQ-009 SHALL have port fetch_ack, input, 1 bit: the fetch unit accepts vec_addr.
REQ-010 SHALL have port pipe_flush, output, 1 bit: request to kill younger instructions.
REQ-011 SHALL have port save_we, output, 1 bit: write strobe for the EPC/cause save registers.
REQ-012 SHALL have port save_epc, output, 32 bits: latched PC.
REQ-013 SHALL have port save_cause, output, 4 bits: latched reason.
REQ-014 SHALL have port vec_valid, output, 1 bit: vec_addr is valid for fetch.
REQ-015 SHALL have port vec_addr, output, 32 bits: trap handler address.
REQ-016 SHALL have port trap_busy, output, 1 bit: the sequencer is not IDLE.
REQ-017 SHALL have port drain_timeout, output, 1 bit: sticky flag, set when the drain wait expired.
REQ-018 SHALL have port trap_lost, output, 1 bit: sticky flag, set when a trap request was dropped.

Function
REQ-019 SHALL implement the FSM states IDLE, DRAIN, SAVE and VECTOR.
REQ-020 SHALL, in IDLE with trap_req=1, latch trap_reason into cause_q and pc_in into epc_q, and move to DRAIN on the next edge.
REQ-021 SHALL drive pipe_flush=1 exactly for the first DRAIN cycle.
REQ-022 SHALL, in DRAIN, count cycles from 0 and move to SAVE when pipe_empty=1 or when the count reaches DRAIN_MAX-1.
REQ-023 SHALL, when DRAIN exits on count expiry with pipe_empty=0, set drain_timeout, which stays set until reset.
REQ-024 SHALL, in SAVE, drive save_we=1 for exactly one cycle with save_epc=epc_q and save_cause=cause_q, then move to VECTOR.
REQ-025 SHALL drive save_epc and save_cause from epc_q and cause_q at all times.
REQ-026 SHALL compute vec_addr = VEC_BASE + {cause_q, 4'b0000}, i.e. 16 bytes per vector, as a 32-bit sum that wraps modulo 2^32.
REQ-027 SHALL, in VECTOR, hold vec_valid=1 and vec_addr stable until fetch_ack=1 is sampled.
REQ-028 SHALL, when fetch_ack=1 is sampled in VECTOR, return to IDLE on that edge, with vec_valid=0 in the following cycle.
REQ-029 SHALL ignore fetch_ack outside VECTOR.
REQ-030 SHALL drive trap_busy=1 in every state except IDLE.
REQ-031 SHALL, when trap_req=1 while not IDLE and TRAP_NEST_EN is undefined, drop the request and set trap_lost.
REQ-032 SHALL, when pipe_empty=1 in the first DRAIN cycle, still assert pipe_flush and move to SAVE after that single DRAIN cycle.

Reset
REQ-033 SHALL, on rst_n=0, immediately force state=IDLE and clear to 0: pipe_flush, save_we, vec_valid, trap_busy, drain_timeout, trap_lost, epc_q, cause_q, the drain counter and the pending slot.
REQ-034 SHALL, on reset mid-sequence, abandon the sequence with no save_we and no vec_valid.
REQ-035 SHALL take the first trap only from the first rising edge after rst_n deasserts.

Configuration
REQ-036 SHALL, with TRAP_NEST_EN defined, provide one pending slot (reason and pc) that captures the first trap_req seen while busy.
REQ-037 SHALL, with TRAP_NEST_EN defined, set trap_lost only when a trap_req arrives while the pending slot is already full.
REQ-038 SHALL, with TRAP_NEST_EN defined, launch a held pending trap on the edge that leaves VECTOR, going straight to DRAIN with no IDLE cycle, and clear the pending slot.
REQ-039 SHALL, with TRAP_NEST_EN undefined, contain no pending slot and behave per REQ-031.

Structure
REQ-040 SHALL place the trap state enum, the TRAP_REASON_W=4 constant and the reason-code localparams in shared package trap_pkg.
REQ-041 SHALL implement the drain counter as sub-module trap_drain_cnt, with inputs start and stop and outputs expired and count.

Verification
REQ-042 SHALL cover: trap_req=1, reason=4'h5, pc=32'h1000, pipe_empty=1 in the 2nd DRAIN cycle -> one pipe_flush pulse, save_we with epc=32'h1000 and cause=5, vec_addr=32'h0000_00D0 held until fetch_ack.
REQ-043 SHALL cover: pipe_empty held 0 with DRAIN_MAX=16 -> SAVE after 16 DRAIN cycles, drain_timeout=1.
REQ-044 SHALL cover: second trap_req during VECTOR with the macro undefined -> trap_lost=1 and only one save_we.
REQ-045 SHALL cover: same stimulus as REQ-044 with TRAP_NEST_EN defined -> second sequence starts in the cycle after fetch_ack, trap_lost=0.
REQ-046 SHALL cover: rst_n=0 asserted in SAVE -> all outputs 0 at once, no vec_valid afterwards.
REQ-047 SHALL cover: VEC_BASE=32'hFFFF_FF00, reason=4'hF -> vec_addr=32'hFFFF_FFF0; VEC_BASE=32'hFFFF_FFF8, reason=4'h1 -> vec_addr=32'h0000_0008.
